fighter_motion: RTL and testbench

- Parametrised per-player motion controller for the two-player fighting game.
- Replaces the fixed right-side enemy controller with one block for either player. SIDE selects the spawn side and the horizontal limits.
- Adds a frame-tick update enable, a latched hit/knockback input with stun timer, and configurable jump physics.
- Sits between the input decoder (keyboard/remote) and the renderer/collision logic. Outputs are the top-left position plus the pose flags.

---
 rtl/fighter_motion.sv | 222 ++++++++++++++++++++++
 tb/tb_fighter_motion.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_motion.sv
// rtl/fighter_motion.sv - per-player motion controller (optional FIGHTER_DOUBLE_JUMP_EN)
module fighter_motion #(
   parameter int SIDE     = 1,
   parameter int XW       = 11,
   parameter int YW       = 10,
   parameter int MAP_X    = 320,
   parameter int MAP_Y    = 240,
   parameter int PLAYER_X = 40,
   parameter int PLAYER_Y = 60,
   parameter int SQUAT_Y  = 30,
   parameter int LIMIT_X  = 280,
   parameter int STEP_X   = 4,
   parameter int V        = 20,
   parameter int G        = 2,
   parameter int KNOCK_X  = 6,
   parameter int STUN_T   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 right,
   input  logic                 left,
   input  logic                 jump,
   input  logic                 squat,
   input  logic                 defend,
   input  logic                 hit,
   input  logic                 hit_dir,
   output logic signed [XW-1:0] x,
   output logic signed [YW-1:0] y,
   output logic                 isD,
   output logic                 isQ,
   output logic                 isJ,
   output logic                 isS
);

   localparam int GND  = -MAP_Y + PLAYER_Y;
   localparam int SQG  = -MAP_Y + SQUAT_Y;
   localparam int XMIN = (SIDE == 1) ? (MAP_X - LIMIT_X) : -MAP_X;
   localparam int XMAX = (SIDE == 1) ? (MAP_X - PLAYER_X) : (-MAP_X + LIMIT_X - PLAYER_X);
   localparam int XRST = (SIDE == 1) ? XMAX : XMIN;
   localparam int SW   = $clog2(STUN_T + 1);

   localparam logic signed [XW:0] XMIN_W = (XW+1)'(XMIN);
   localparam logic signed [XW:0] XMAX_W = (XW+1)'(XMAX);

   localparam logic [1:0] ST_GROUND = 2'd0;
   localparam logic [1:0] ST_SQUAT  = 2'd1;
   localparam logic [1:0] ST_JUMP   = 2'd2;

   logic signed [XW-1:0] x_q, x_d;
   logic signed [YW-1:0] y_q, y_d;
   logic signed [YW-1:0] base_q, base_d;
   logic [1:0]           state_q, state_d;
   logic [5:0]           jcnt_q, jcnt_d;
   logic [SW-1:0]        stun_cnt_q, stun_cnt_d;
   logic                 hit_pend_q, hit_pend_d;
   logic                 hit_dir_q, hit_dir_d;
   logic                 knock_dir_q, knock_dir_d;
   logic                 isD_q, isD_d;
`ifdef FIGHTER_DOUBLE_JUMP_EN
   logic                 jump_d_q, jump_d_d;
   logic                 dj_used_q, dj_used_d;
`endif

   logic                 stunned;
   logic                 stun_start;
   logic                 gated;
   logic signed [XW:0]   dx;
   logic signed [XW:0]   x_sum;
   int                   j_i;
   int                   arc;

   // next-state: hit latch always, motion and pose only on frame ticks
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      base_d      = base_q;
      state_d     = state_q;
      jcnt_d      = jcnt_q;
      stun_cnt_d  = stun_cnt_q;
      hit_dir_d   = hit_dir_q;
      knock_dir_d = knock_dir_q;
      isD_d       = isD_q;
`ifdef FIGHTER_DOUBLE_JUMP_EN
      jump_d_d    = jump_d_q;
      dj_used_d   = dj_used_q;
`endif
      dx          = '0;
      x_sum       = '0;
      j_i         = int'(jcnt_q);
      arc         = int'(base_q) + V * j_i - (G * j_i * j_i) / 2;

      stunned    = (stun_cnt_q != '0);
      stun_start = hit_pend_q & ~isD_q & ~stunned;
      gated      = stunned | stun_start;

      // a hit landing on the tick cycle itself is kept for the following tick
      if (tick) hit_pend_d = hit;
      else      hit_pend_d = hit_pend_q | hit;
      if (hit) hit_dir_d = hit_dir;

      if (tick) begin
         // knockback direction is frozen when the stun starts
         if (stun_start) begin
            stun_cnt_d  = SW'(STUN_T);
            knock_dir_d = hit_dir_q;
         end else if (stunned) begin
            stun_cnt_d = stun_cnt_q - SW'(1);
         end

         if (stunned)     dx = knock_dir_q ? (XW+1)'(KNOCK_X) : -((XW+1)'(KNOCK_X));
         else if (!gated) begin
            if (right)     dx = (XW+1)'(STEP_X);
            else if (left) dx = -((XW+1)'(STEP_X));
         end
         x_sum = {x_q[XW-1], x_q} + dx;
         if (x_sum < XMIN_W)      x_d = XMIN_W[XW-1:0];
         else if (x_sum > XMAX_W) x_d = XMAX_W[XW-1:0];
         else                     x_d = x_sum[XW-1:0];

         case (state_q)
            ST_GROUND: begin
               y_d = YW'(GND);
               if (!gated && jump) begin
                  state_d = ST_JUMP;
                  jcnt_d  = 6'd1;
                  base_d  = YW'(GND);
               end else if (!gated && squat) begin
                  state_d = ST_SQUAT;
                  y_d     = YW'(SQG);
               end
            end
            ST_SQUAT: begin
               if (gated || !squat) begin
                  state_d = ST_GROUND;
                  y_d     = YW'(GND);
               end else if (jump) begin
                  state_d = ST_JUMP;
                  jcnt_d  = 6'd1;
                  base_d  = YW'(GND);
                  y_d     = YW'(GND);
               end else begin
                  y_d = YW'(SQG);
               end
            end
            ST_JUMP: begin
`ifdef FIGHTER_DOUBLE_JUMP_EN
               if (!gated && jump && !jump_d_q && !dj_used_q) begin
                  base_d    = y_q;
                  jcnt_d    = 6'd1;
                  dj_used_d = 1'b1;
               end else
`endif
               if (jcnt_q == 6'd63 || arc <= GND) begin
                  y_d     = YW'(GND);
                  jcnt_d  = 6'd0;
                  state_d = ST_GROUND;
`ifdef FIGHTER_DOUBLE_JUMP_EN
                  dj_used_d = 1'b0;
`endif
               end else begin
                  y_d    = YW'(arc);
                  jcnt_d = jcnt_q + 6'd1;
               end
            end
            default: begin
               state_d = ST_GROUND;
               y_d     = YW'(GND);
               jcnt_d  = 6'd0;
            end
         endcase

         isD_d = defend & (stun_cnt_d == '0) & (state_d != ST_JUMP);
`ifdef FIGHTER_DOUBLE_JUMP_EN
         jump_d_d = jump;
`endif
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q         <= XW'(XRST);
         y_q         <= YW'(GND);
         base_q      <= YW'(GND);
         state_q     <= ST_GROUND;
         jcnt_q      <= 6'd0;
         stun_cnt_q  <= '0;
         hit_pend_q  <= 1'b0;
         hit_dir_q   <= 1'b0;
         knock_dir_q <= 1'b0;
         isD_q       <= 1'b0;
`ifdef FIGHTER_DOUBLE_JUMP_EN
         jump_d_q    <= 1'b0;
         dj_used_q   <= 1'b0;
`endif
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         base_q      <= base_d;
         state_q     <= state_d;
         jcnt_q      <= jcnt_d;
         stun_cnt_q  <= stun_cnt_d;
         hit_pend_q  <= hit_pend_d;
         hit_dir_q   <= hit_dir_d;
         knock_dir_q <= knock_dir_d;
         isD_q       <= isD_d;
`ifdef FIGHTER_DOUBLE_JUMP_EN
         jump_d_q    <= jump_d_d;
         dj_used_q   <= dj_used_d;
`endif
      end
   end

   assign x   = x_q;
   assign y   = y_q;
   assign isD = isD_q;
   assign isJ = (state_q == ST_JUMP);
   assign isS = (stun_cnt_q != '0);
   assign isQ = (state_q == ST_SQUAT) & ~isS;

endmodule

// File: tb/tb_fighter_motion.sv
// tb/tb_fighter_motion.sv - scoreboard bench for fighter_motion
module tb_fighter_motion;

   localparam logic [3:0] F_D = 4'b1000;
   localparam logic [3:0] F_Q = 4'b0100;
   localparam logic [3:0] F_J = 4'b0010;
   localparam logic [3:0] F_S = 4'b0001;

   typedef struct {
      string      name;
      int         ex;
      int         ey;
      logic [3:0] fl;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic clk = 1'b0;
   logic rst_n, tick, right, left, jump, squat, defend, hit, hit_dir;
   logic signed [10:0] x, x_l;
   logic signed [9:0]  y, y_l;
   logic isD, isQ, isJ, isS;
   logic isD_l, isQ_l, isJ_l, isS_l;
   logic [3:0] flags;

   assign flags = {isD, isQ, isJ, isS};

   always #5 clk = ~clk;

   fighter_motion #(.SIDE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .right(right), .left(left),
      .jump(jump), .squat(squat), .defend(defend), .hit(hit), .hit_dir(hit_dir),
      .x(x), .y(y), .isD(isD), .isQ(isQ), .isJ(isJ), .isS(isS)
   );

   fighter_motion #(.SIDE(0)) u_left (
      .clk(clk), .rst_n(rst_n), .tick(tick), .right(right), .left(left),
      .jump(jump), .squat(squat), .defend(defend), .hit(hit), .hit_dir(hit_dir),
      .x(x_l), .y(y_l), .isD(isD_l), .isQ(isQ_l), .isJ(isJ_l), .isS(isS_l)
   );

   task automatic pulse_tick();
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic hit_pulse(input logic dir);
      hit = 1'b1;
      hit_dir = dir;
      @(posedge clk);
      #1;
      hit = 1'b0;
   endtask

   task automatic clear_inputs();
      right = 0; left = 0; jump = 0; squat = 0; defend = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (x !== 11'sd280 || y !== -10'sd180 || flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_right: x=%0d y=%0d DQJS=%b, expected x=280 y=-180 DQJS=0000", x, y, flags);
      end
      n_checks++;
      if (x_l !== -11'sd320 || y_l !== -10'sd180 || {isD_l, isQ_l, isJ_l, isS_l} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_left: x=%0d y=%0d, expected x=-320 y=-180 flags 0", x_l, y_l);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back('{"idle_tick", 280, -180, 4'b0000});
      pulse_tick();
      e = exp_q.pop_front();
      n_checks++;
      if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
         n_fail++;
         $display("FAIL %s: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, x, y, flags, e.ex, e.ey, e.fl);
      end
   endtask

   task automatic test_walk();
      int ex;
      for (int i = 0; i < 178; i++) begin
         clear_inputs();
         if (i < 3) begin
            right = 1; ex = 280;
         end else if (i < 108) begin
            left = 1; right = (i == 50); left = 1;
            right = 0;
            ex = 280 - 4 * (i - 2);
            if (ex < 40) ex = 40;
         end else begin
            right = 1;
            ex = 40 + 4 * (i - 107);
            if (ex > 280) ex = 280;
         end
         exp_q.push_back('{"walk", ex, -180, 4'b0000});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
      clear_inputs();
   endtask

   task automatic test_jump();
      int ey, k;
      logic [3:0] ef;
      for (int i = 0; i < 45; i++) begin
         clear_inputs();
         ef = 4'b0000;
         ey = -180;
         if (i == 0) begin
            jump = 1; ef = F_J;
         end else if (i <= 20) begin
`ifndef FIGHTER_DOUBLE_JUMP_EN
            jump = (i == 11);
`endif
            ey = -180 + 20 * i - i * i;
            if (i < 20) ef = F_J;
         end else if (i == 21) begin
            jump = 1; squat = 1; ef = F_J;
         end else if (i <= 41) begin
            k = i - 21;
            ey = -180 + 20 * k - k * k;
            if (k < 20) ef = F_J;
         end else if (i <= 43) begin
            squat = 1; ey = -210; ef = F_Q;
         end
         exp_q.push_back('{"jump", 280, ey, ef});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
      clear_inputs();
   endtask

   task automatic test_stun();
      int ex, k;
      logic [3:0] ef;
      for (int i = 0; i < 20; i++) begin
         clear_inputs();
         if (i == 0) begin
            hit_pulse(1'b1);
            hit_pulse(1'b0);
         end
         if (i == 11) hit_pulse(1'b1);
         ef = 4'b0000;
         if (i == 0) begin
            ex = 280; ef = F_S;
         end else if (i <= 8) begin
            if (i <= 7) begin
               right = 1; jump = 1; squat = 1; defend = 1;
            end
            ex = 280 - 6 * i;
            if (i < 8) ef = F_S;
         end else if (i <= 10) begin
            right = 1;
            ex = 232 + 4 * (i - 8);
         end else if (i == 11) begin
            ex = 240; ef = F_S;
         end else begin
            k = i - 11;
            ex = 240 + 6 * k;
            if (ex > 280) ex = 280;
            if (k < 8) ef = F_S;
         end
         exp_q.push_back('{"stun", ex, -180, ef});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
      clear_inputs();
   endtask

   task automatic test_defend();
      logic [3:0] ef;
      for (int i = 0; i < 4; i++) begin
         clear_inputs();
         if (i == 1) hit_pulse(1'b0);
         defend = (i < 2);
         ef = (i < 2) ? F_D : 4'b0000;
         exp_q.push_back('{"defend", 280, -180, ef});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_jump();
      int ex, ey, k;
      logic [3:0] ef;
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         ef = F_J;
         ex = 272;
         ey = -180;
         if (i < 2) begin
            left = 1; ex = 276 - 4 * i; ef = 4'b0000;
         end else if (i == 2) begin
            jump = 1;
         end else begin
            k = i - 2;
            ey = -180 + 20 * k - k * k;
         end
         exp_q.push_back('{"pre_reset", ex, ey, ef});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
      clear_inputs();
      hit_pulse(1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_checks++;
      if (x !== 11'sd280 || y !== -10'sd180 || flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_jump_reset: x=%0d y=%0d DQJS=%b, expected x=280 y=-180 DQJS=0000", x, y, flags);
      end
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{"post_reset", 280, -180, 4'b0000});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
   endtask

`ifdef FIGHTER_DOUBLE_JUMP_EN
   task automatic test_air_jump();
      int ey, k;
      logic [3:0] ef;
      for (int i = 0; i < 37; i++) begin
         clear_inputs();
         ef = F_J;
         if (i == 0) begin
            jump = 1; ey = -180;
         end else if (i <= 10) begin
            ey = -180 + 20 * i - i * i;
         end else if (i == 11) begin
            jump = 1; ey = -80;
         end else begin
            k = i - 11;
            jump = (k == 3);
            ey = -80 + 20 * k - k * k;
            if (ey <= -180) begin
               ey = -180; ef = 4'b0000;
            end
            if (k > 25) begin
               ey = -180; ef = 4'b0000;
            end
         end
         exp_q.push_back('{"air_jump", 280, ey, ef});
         pulse_tick();
         e = exp_q.pop_front();
         n_checks++;
         if (x !== 11'(e.ex) || y !== 10'(e.ey) || flags !== e.fl) begin
            n_fail++;
            $display("FAIL %s[%0d]: x=%0d y=%0d DQJS=%b, expected x=%0d y=%0d DQJS=%b", e.name, i, x, y, flags, e.ex, e.ey, e.fl);
         end
      end
      clear_inputs();
   endtask
`endif

   initial begin
      rst_n = 0; tick = 0; hit = 0; hit_dir = 0;
      clear_inputs();
      test_reset();
      test_walk();
      test_jump();
      test_stun();
      test_defend();
      test_reset_mid_jump();
`ifdef FIGHTER_DOUBLE_JUMP_EN
      test_air_jump();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
